// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch slice.
package fetch_pkg;

  typedef enum logic [1:0] {
    ISSUE = 2'd0,
    WAIT  = 2'd1,
    IDLE  = 2'd2
  } state_t;

  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [31:0] PC_INC        = 32'd4;

endpackage

// File: rtl/instr_fetch_unit_sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// PC owner and single-outstanding instruction fetcher feeding decode through
// a valid/ready register slice, with branch redirect and wrong-path kill.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_rvalid,
  input  logic [31:0]      imem_rdata,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  output logic [31:0]      instr,
  output logic [31:0]      instr_pc,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic             align_err,
  output logic [CNT_W-1:0] fetch_cnt,
  output logic [CNT_W-1:0] kill_cnt
);

  state_t      state, state_nx;
  logic [31:0] pc;
  logic [31:0] instr_q;
  logic        kill;
  logic        space, resp, drop, load, hs;

  assign space = !instr_valid || instr_ready;
  assign resp  = (state == WAIT) && imem_rvalid;
  assign drop  = resp && (kill || redirect_valid);
  assign load  = resp && !kill && !redirect_valid;
  assign hs    = instr_valid && instr_ready && !redirect_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ISSUE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ISSUE: state_nx = WAIT;
      WAIT: begin
        if (redirect_valid)   state_nx = imem_rvalid ? ISSUE : WAIT;
        else if (imem_rvalid) state_nx = (kill && space) ? ISSUE : IDLE;
      end
      IDLE:    if (redirect_valid || space) state_nx = ISSUE;
      default: state_nx = ISSUE;
    endcase
  end

  // Request is masked during reset so nothing leaves before deassertion.
  always_comb begin
    imem_req  = (state == ISSUE) && !rst;
    imem_addr = pc;
    instr     = instr_valid ? instr_q : NOP_INSTR;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      kill        <= 1'b0;
      instr_q     <= NOP_INSTR;
      instr_pc    <= RESET_PC;
      instr_valid <= 1'b0;
      align_err   <= 1'b0;
    end else begin
      align_err <= redirect_valid && (redirect_pc[1:0] != 2'b00);
      if (redirect_valid) begin
        pc          <= {redirect_pc[31:2], 2'b00};
        instr_valid <= 1'b0;
        // Kill stays armed across repeated redirects until its response lands.
        kill        <= (state == ISSUE) || ((state == WAIT) && !imem_rvalid);
      end else if (load) begin
        instr_q     <= imem_rdata;
        instr_pc    <= pc;
        instr_valid <= 1'b1;
        pc          <= pc + PC_INC;
      end else begin
        if (drop) kill        <= 1'b0;
        if (hs)   instr_valid <= 1'b0;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_fetch_cnt (
    .clk (clk),
    .rst (rst),
    .inc (hs),
    .cnt (fetch_cnt)
  );

  sat_counter #(.W(CNT_W)) u_kill_cnt (
    .clk (clk),
    .rst (rst),
    .inc (drop),
    .cnt (kill_cnt)
  );

endmodule
